// File: rtl/i2c_target_regs.sv
// -----------------------------------------------------------------------------
// i2c_target_regs
//
// I2C target that accepts 16-bit-address / 8-bit-data register writes and
// presents each written byte as a single-cycle strobe. Used both as an
// FPGA-side configuration port and as a bus model of the HM0360 sensor.
// SDA is open-drain (driven low or released). SCL is only ever read, so the
// target never stretches the clock.
//
// Parameters
//   DEV_ID      7-bit target address, matched against address byte [7:1]
//   FILTER_LEN  clocks a synchronised line must hold a new level before the
//               filtered copy follows it
//
// Ports
//   clk_i       system clock (single domain)
//   rst_i       asynchronous active-high reset
//   sda_io      I2C data line (0 or Z only)
//   scl_io      I2C clock line (input only, never driven)
//   wr_valid_o  one-cycle strobe: a data byte was written
//   wr_addr_o   register address of the last write (held)
//   wr_data_o   data byte of the last write (held)
//   rd_req_o    one-cycle read request (read build only, else 0)
//   rd_addr_o   register address of the last read request (held)
//   rd_data_i   read data, valid the cycle after rd_req_o and held
//   busy_o      high from an address match until STOP / next START
//
// Build option
//   I2C_TARGET_READ_EN  when defined, matched reads (R/W=1) are ACKed and
//                       served from rd_data_i; otherwise they are NAKed and
//                       the read outputs are tied to zero.
// -----------------------------------------------------------------------------
module i2c_target_regs #(
    parameter logic [6:0] DEV_ID     = 7'h35,
    parameter int         FILTER_LEN = 3
) (
    input  logic        clk_i,
    input  logic        rst_i,
    inout  wire         sda_io,
    inout  wire         scl_io,
    output logic        wr_valid_o,
    output logic [15:0] wr_addr_o,
    output logic [7:0]  wr_data_o,
    output logic        rd_req_o,
    output logic [15:0] rd_addr_o,
    input  logic [7:0]  rd_data_i,
    output logic        busy_o
);

    typedef enum logic [2:0] {
        ST_IDLE, ST_ADDR, ST_REG_HI, ST_REG_LO, ST_WDATA, ST_RDATA, ST_IGNORE
    } state_t;

    localparam int FCW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

    // ---------------- input conditioning: 2-FF sync + stability filter -----
    // Index 1 = SCL, index 0 = SDA. Both lines use identical pipelines so
    // their relative ordering is preserved through the filter.
    logic [1:0] line_raw;
    logic [1:0] line_filt;
    logic [1:0] line_prev_q;

    assign line_raw = {scl_io, sda_io};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_line
            logic           meta_q;
            logic           sync_q;
            logic           filt_q;
            logic [FCW-1:0] stable_cnt_q;

            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    meta_q       <= 1'b1;
                    sync_q       <= 1'b1;
                    filt_q       <= 1'b1;
                    stable_cnt_q <= '0;
                end else begin
                    meta_q <= line_raw[gi];
                    sync_q <= meta_q;
                    if (sync_q == filt_q) begin
                        stable_cnt_q <= '0;
                    end else if (stable_cnt_q == FCW'(FILTER_LEN - 1)) begin
                        filt_q       <= sync_q;
                        stable_cnt_q <= '0;
                    end else begin
                        stable_cnt_q <= stable_cnt_q + FCW'(1);
                    end
                end
            end

            assign line_filt[gi] = filt_q;
        end
    endgenerate

    logic scl;
    logic sda;
    logic scl_rise;
    logic scl_fall;
    logic start_det;
    logic stop_det;

    assign scl       = line_filt[1];
    assign sda       = line_filt[0];
    assign scl_rise  = scl & ~line_prev_q[1];
    assign scl_fall  = ~scl & line_prev_q[1];
    assign start_det = scl & line_prev_q[1] & line_prev_q[0] & ~sda;
    assign stop_det  = scl & line_prev_q[1] & ~line_prev_q[0] & sda;

    // ---------------- protocol state -----------------------------------------
    // cnt_q counts SCL rises in the current 9-clock frame: 1..8 are data bits,
    // 9 is the acknowledge clock. The state advances on the 8th rise, so the
    // acknowledge slot (cnt 8/9) is handled in the following state using ack_q.
    state_t      state_q,    state_d;
    logic [3:0]  cnt_q,      cnt_d;
    logic [6:0]  shift_q,    shift_d;
    logic        ack_q,      ack_d;
    logic        sda_low_q,  sda_low_d;
    logic [15:0] ptr_q,      ptr_d;
    logic        wr_valid_q, wr_valid_d;
    logic [15:0] wr_addr_q,  wr_addr_d;
    logic [7:0]  wr_data_q,  wr_data_d;
    logic        busy_q,     busy_d;
    logic [7:0]  byte_in;

`ifdef I2C_TARGET_READ_EN
    logic        rd_req_q,   rd_req_d;
    logic [15:0] rd_addr_q,  rd_addr_d;
    logic        rd_cap_q,   rd_cap_d;
    logic [7:0]  tx_q,       tx_d;
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        ack_d      = ack_q;
        sda_low_d  = sda_low_q;
        ptr_d      = ptr_q;
        wr_valid_d = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        busy_d     = busy_q;
`ifdef I2C_TARGET_READ_EN
        rd_req_d   = 1'b0;
        rd_addr_d  = rd_addr_q;
        // rd_data_i is valid the cycle after the request, so capture one
        // cycle after rd_req_q was high.
        rd_cap_d   = rd_req_q;
        tx_d       = rd_cap_q ? rd_data_i : tx_q;
`endif
        byte_in    = {shift_q, sda};

        if (stop_det || start_det) begin
            // Any partial byte is dropped and the line released at once.
            state_d   = stop_det ? ST_IDLE : ST_ADDR;
            cnt_d     = '0;
            ack_d     = 1'b0;
            sda_low_d = 1'b0;
            busy_d    = 1'b0;
        end else if (state_q != ST_IDLE && state_q != ST_IGNORE) begin
            if (scl_rise) begin
                if (cnt_q < 4'd8) begin
                    shift_d = byte_in[6:0];
                    cnt_d   = cnt_q + 4'd1;
                    if (cnt_q == 4'd7) begin
                        ack_d = 1'b1;
                        case (state_q)
                            ST_ADDR: begin
                                if (byte_in[7:1] != DEV_ID) begin
                                    ack_d   = 1'b0;
                                    state_d = ST_IGNORE;
                                end else if (!byte_in[0]) begin
                                    state_d = ST_REG_HI;
                                    busy_d  = 1'b1;
                                end else begin
`ifdef I2C_TARGET_READ_EN
                                    state_d   = ST_RDATA;
                                    busy_d    = 1'b1;
                                    rd_req_d  = 1'b1;
                                    rd_addr_d = ptr_q;
`else
                                    ack_d   = 1'b0;
                                    state_d = ST_IGNORE;
`endif
                                end
                            end
                            ST_REG_HI: begin
                                state_d      = ST_REG_LO;
                                ptr_d[15:8]  = byte_in;
                            end
                            ST_REG_LO: begin
                                state_d      = ST_WDATA;
                                ptr_d[7:0]   = byte_in;
                            end
                            ST_WDATA: begin
                                wr_valid_d = 1'b1;
                                wr_addr_d  = ptr_q;
                                wr_data_d  = byte_in;
                                ptr_d      = ptr_q + 16'd1;
                            end
`ifdef I2C_TARGET_READ_EN
                            ST_RDATA: begin
                                // Data we sent is acknowledged by the initiator.
                                ack_d = 1'b0;
                            end
`endif
                            default: begin
                            end
                        endcase
                    end
                end else if (cnt_q == 4'd8) begin
                    cnt_d = 4'd9;
`ifdef I2C_TARGET_READ_EN
                    // ack_q clear here means this was a read-data frame and
                    // the initiator owns the acknowledge bit.
                    if (state_q == ST_RDATA && !ack_q) begin
                        ptr_d = ptr_q + 16'd1;
                        if (!sda) begin
                            rd_req_d  = 1'b1;
                            rd_addr_d = ptr_q + 16'd1;
                        end else begin
                            state_d = ST_IGNORE;
                        end
                    end
`endif
                end
            end else if (scl_fall) begin
                if (cnt_q == 4'd8) begin
                    sda_low_d = ack_q;
                end else if (cnt_q == 4'd9) begin
                    cnt_d     = '0;
                    sda_low_d = 1'b0;
`ifdef I2C_TARGET_READ_EN
                    if (state_q == ST_RDATA) begin
                        sda_low_d = ~tx_q[7];
                        tx_d      = {tx_q[6:0], 1'b0};
                    end
`endif
                end
`ifdef I2C_TARGET_READ_EN
                else if (state_q == ST_RDATA && cnt_q != 4'd0) begin
                    sda_low_d = ~tx_q[7];
                    tx_d      = {tx_q[6:0], 1'b0};
                end
`endif
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            line_prev_q <= 2'b11;
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            shift_q     <= '0;
            ack_q       <= 1'b0;
            sda_low_q   <= 1'b0;
            ptr_q       <= '0;
            wr_valid_q  <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            busy_q      <= 1'b0;
`ifdef I2C_TARGET_READ_EN
            rd_req_q    <= 1'b0;
            rd_addr_q   <= '0;
            rd_cap_q    <= 1'b0;
            tx_q        <= '0;
`endif
        end else begin
            line_prev_q <= line_filt;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            ack_q       <= ack_d;
            sda_low_q   <= sda_low_d;
            ptr_q       <= ptr_d;
            wr_valid_q  <= wr_valid_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            busy_q      <= busy_d;
`ifdef I2C_TARGET_READ_EN
            rd_req_q    <= rd_req_d;
            rd_addr_q   <= rd_addr_d;
            rd_cap_q    <= rd_cap_d;
            tx_q        <= tx_d;
`endif
        end
    end

    assign sda_io     = sda_low_q ? 1'b0 : 1'bz;
    assign wr_valid_o = wr_valid_q;
    assign wr_addr_o  = wr_addr_q;
    assign wr_data_o  = wr_data_q;
    assign busy_o     = busy_q;

`ifdef I2C_TARGET_READ_EN
    assign rd_req_o  = rd_req_q;
    assign rd_addr_o = rd_addr_q;
`else
    logic unused_rd_data;
    assign unused_rd_data = ^rd_data_i;
    assign rd_req_o  = 1'b0;
    assign rd_addr_o = '0;
`endif

endmodule

// File: tb/tb_i2c_target_regs.sv
// -----------------------------------------------------------------------------
// tb_i2c_target_regs
//
// Bench for i2c_target_regs. A bit-banged I2C initiator issues directed
// transactions; expected write/read strobes are queued when issued and a
// monitor pops and compares them whenever the target raises wr_valid/rd_req.
// Acknowledge bits and read bytes are checked as they are clocked.
// Read-path expectations follow the I2C_TARGET_READ_EN build option.
// -----------------------------------------------------------------------------
module tb_i2c_target_regs;

    localparam int Q = 10;   // clocks per quarter SCL period

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        m_sda_low;
    logic        scl_drv;
    wire         sda_bus;
    wire         scl_bus;
    logic        wr_valid;
    logic [15:0] wr_addr;
    logic [7:0]  wr_data;
    logic        rd_req;
    logic [15:0] rd_addr;
    logic [7:0]  rd_data;
    logic        busy;

    assign sda_bus = m_sda_low ? 1'b0 : 1'bz;
    pullup (sda_bus);
    assign scl_bus = scl_drv;

    i2c_target_regs dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .sda_io     (sda_bus),
        .scl_io     (scl_bus),
        .wr_valid_o (wr_valid),
        .wr_addr_o  (wr_addr),
        .wr_data_o  (wr_data),
        .rd_req_o   (rd_req),
        .rd_addr_o  (rd_addr),
        .rd_data_i  (rd_data),
        .busy_o     (busy)
    );

    // Register-file model behind the read port: returns the low address byte.
    initial rd_data = 8'h00;
    always @(posedge clk) if (rd_req) rd_data <= rd_addr[7:0];

    int n_checks = 0;
    int n_pass   = 0;
    int n_rd     = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
            $display("check %-18s ok   got %0h", name, act);
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- scoreboard ----------------
    logic [31:0] wr_q [$];
    logic [31:0] rd_q [$];

    always @(negedge clk) begin
        if (!rst) begin
            if (wr_valid) begin
                chk("wr_strobe", {8'h00, wr_addr, wr_data},
                    (wr_q.size() != 0) ? wr_q.pop_front() : 32'hFF00_0000);
                chk("wr_rd_exclusive", {31'b0, rd_req}, 32'd0);
            end
            if (rd_req) begin
                n_rd++;
                chk("rd_request", {16'h0000, rd_addr},
                    (rd_q.size() != 0) ? rd_q.pop_front() : 32'hFF00_0000);
            end
        end
    end

    // Watches the bus during the foreign-address transaction.
    logic watch = 1'b0;
    logic dut_pull_seen = 1'b0;
    logic busy_seen = 1'b0;
    always @(negedge clk) begin
        if (watch) begin
            if (sda_bus === 1'b0 && !m_sda_low) dut_pull_seen <= 1'b1;
            if (busy) busy_seen <= 1'b1;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // ---------------- initiator tasks ----------------
    task automatic qwait(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic i2c_start;
        m_sda_low = 1'b1; qwait(Q);
        scl_drv   = 1'b0; qwait(Q);
    endtask

    task automatic i2c_rstart;
        m_sda_low = 1'b0; qwait(Q);
        scl_drv   = 1'b1; qwait(Q);
        m_sda_low = 1'b1; qwait(Q);
        scl_drv   = 1'b0; qwait(Q);
    endtask

    task automatic i2c_stop;
        m_sda_low = 1'b1; qwait(Q);
        scl_drv   = 1'b1; qwait(Q);
        m_sda_low = 1'b0; qwait(2 * Q);
    endtask

    task automatic send_bit(input logic b);
        m_sda_low = ~b;   qwait(Q);
        scl_drv   = 1'b1; qwait(2 * Q);
        scl_drv   = 1'b0; qwait(Q);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic exp_ack, input string name);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        m_sda_low = 1'b0; qwait(Q);
        scl_drv   = 1'b1; qwait(Q);
        #1;
        chk(name, {31'b0, sda_bus}, exp_ack ? 32'd0 : 32'd1);
        qwait(Q);
        scl_drv   = 1'b0; qwait(Q);
    endtask

    task automatic read_byte(input logic [7:0] exp, input logic m_ack, input string name);
        logic [7:0] got;
        got = 8'h00;
        m_sda_low = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            qwait(Q);
            scl_drv = 1'b1; qwait(Q);
            #1 got[i] = sda_bus;
            qwait(Q);
            scl_drv = 1'b0; qwait(Q);
        end
        m_sda_low = m_ack; qwait(Q);
        scl_drv   = 1'b1;  qwait(2 * Q);
        scl_drv   = 1'b0;  qwait(Q);
        chk(name, {24'h0, got}, {24'h0, exp});
    endtask

    task automatic expect_wr(input logic [15:0] a, input logic [7:0] d);
        wr_q.push_back({8'h00, a, d});
    endtask

    // Init-sequencer word list: {address, data}.
    logic [23:0] seq_tbl [4] = '{24'h0103_01, 24'h3034_40, 24'h0100_00, 24'h2000_5A};

    initial begin
        rst       = 1'b1;
        m_sda_low = 1'b0;
        scl_drv   = 1'b1;
        qwait(5);
        #1;
        chk("rst_wr_valid", {31'b0, wr_valid}, 32'd0);
        chk("rst_wr_addr",  {16'h0, wr_addr}, 32'd0);
        chk("rst_wr_data",  {24'h0, wr_data}, 32'd0);
        chk("rst_rd_req",   {31'b0, rd_req}, 32'd0);
        chk("rst_rd_addr",  {16'h0, rd_addr}, 32'd0);
        chk("rst_busy",     {31'b0, busy}, 32'd0);
        chk("rst_sda",      {31'b0, sda_bus}, 32'd1);
        rst = 1'b0;
        qwait(2 * Q);

        // Single write 0x0103 <= 0x01.
        i2c_start;
        send_byte(8'h6A, 1'b1, "t1_ack_addr");
        #1 chk("t1_busy_on", {31'b0, busy}, 32'd1);
        send_byte(8'h01, 1'b1, "t1_ack_hi");
        send_byte(8'h03, 1'b1, "t1_ack_lo");
        expect_wr(16'h0103, 8'h01);
        send_byte(8'h01, 1'b1, "t1_ack_data");
        i2c_stop;
        #1 chk("t1_busy_off", {31'b0, busy}, 32'd0);

        // Burst.
        i2c_start;
        send_byte(8'h6A, 1'b1, "t2_ack_addr");
        send_byte(8'h30, 1'b1, "t2_ack_hi");
        send_byte(8'h10, 1'b1, "t2_ack_lo");
        expect_wr(16'h3010, 8'hAA); send_byte(8'hAA, 1'b1, "t2_ack_d0");
        expect_wr(16'h3011, 8'hBB); send_byte(8'hBB, 1'b1, "t2_ack_d1");
        expect_wr(16'h3012, 8'hCC); send_byte(8'hCC, 1'b1, "t2_ack_d2");
        i2c_stop;

        // Foreign address 0x40: NAK, never driven, not busy.
        watch = 1'b1;
        i2c_start;
        send_byte(8'h80, 1'b0, "t3_nak_addr");
        send_byte(8'h12, 1'b0, "t3_nak_b1");
        send_byte(8'h34, 1'b0, "t3_nak_b2");
        i2c_stop;
        watch = 1'b0;
        #1;
        chk("t3_dut_never_pull", {31'b0, dut_pull_seen}, 32'd0);
        chk("t3_busy_never", {31'b0, busy_seen}, 32'd0);
        i2c_start;
        send_byte(8'h6A, 1'b1, "t3_ack_addr");
        send_byte(8'h00, 1'b1, "t3_ack_hi");
        send_byte(8'h05, 1'b1, "t3_ack_lo");
        expect_wr(16'h0005, 8'h77); send_byte(8'h77, 1'b1, "t3_ack_data");
        i2c_stop;

        // Pointer wrap.
        i2c_start;
        send_byte(8'h6A, 1'b1, "t4_ack_addr");
        send_byte(8'hFF, 1'b1, "t4_ack_hi");
        send_byte(8'hFF, 1'b1, "t4_ack_lo");
        expect_wr(16'hFFFF, 8'h11); send_byte(8'h11, 1'b1, "t4_ack_d0");
        expect_wr(16'h0000, 8'h22); send_byte(8'h22, 1'b1, "t4_ack_d1");
        i2c_stop;

        // STOP after 5 data bits: partial byte discarded.
        i2c_start;
        send_byte(8'h6A, 1'b1, "t5_ack_addr");
        send_byte(8'h00, 1'b1, "t5_ack_hi");
        send_byte(8'h10, 1'b1, "t5_ack_lo");
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        i2c_stop;
        #1 chk("t5_busy_off", {31'b0, busy}, 32'd0);
        i2c_start;
        send_byte(8'h6A, 1'b1, "t5_ack_addr2");
        send_byte(8'h00, 1'b1, "t5_ack_hi2");
        send_byte(8'h10, 1'b1, "t5_ack_lo2");
        expect_wr(16'h0010, 8'h5A); send_byte(8'h5A, 1'b1, "t5_ack_data");
        i2c_stop;

        // Repeated START after 3 bits of a data byte.
        i2c_start;
        send_byte(8'h6A, 1'b1, "t6_ack_addr");
        send_byte(8'h00, 1'b1, "t6_ack_hi");
        send_byte(8'h40, 1'b1, "t6_ack_lo");
        send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
        i2c_rstart;
        send_byte(8'h6A, 1'b1, "t6_ack_addr2");
        send_byte(8'h00, 1'b1, "t6_ack_hi2");
        send_byte(8'h41, 1'b1, "t6_ack_lo2");
        expect_wr(16'h0041, 8'h99); send_byte(8'h99, 1'b1, "t6_ack_data");
        i2c_stop;

        // Read: set pointer 0x0020, repeated START, read two bytes.
        i2c_start;
        send_byte(8'h6A, 1'b1, "t7_ack_addr");
        send_byte(8'h00, 1'b1, "t7_ack_hi");
        send_byte(8'h20, 1'b1, "t7_ack_lo");
        i2c_rstart;
`ifdef I2C_TARGET_READ_EN
        rd_q.push_back(32'h0000_0020);
        rd_q.push_back(32'h0000_0021);
        send_byte(8'h6B, 1'b1, "t7_ack_rd_addr");
        read_byte(8'h20, 1'b1, "t7_rd_byte0");
        read_byte(8'h21, 1'b0, "t7_rd_byte1");
        i2c_stop;
        chk("t7_rd_req_count", n_rd, 32'd2);
`else
        send_byte(8'h6B, 1'b0, "t7_nak_rd_addr");
        i2c_stop;
        chk("t7_rd_req_count", n_rd, 32'd0);
`endif

        // Init-sequencer style words, one transaction each.
        for (int i = 0; i < 4; i++) begin
            i2c_start;
            send_byte(8'h6A, 1'b1, "t8_ack_addr");
            send_byte(seq_tbl[i][23:16], 1'b1, "t8_ack_hi");
            send_byte(seq_tbl[i][15:8], 1'b1, "t8_ack_lo");
            expect_wr(seq_tbl[i][23:8], seq_tbl[i][7:0]);
            send_byte(seq_tbl[i][7:0], 1'b1, "t8_ack_data");
            i2c_stop;
        end

        // Reset asserted while the target is pulling SDA for an ACK.
        i2c_start;
        for (int i = 7; i >= 0; i--) send_bit(8'h6A >> i);
        m_sda_low = 1'b0;
        qwait(Q);
        #1 chk("t9_ack_driven", {31'b0, sda_bus}, 32'd0);
        rst = 1'b1;
        #1;
        chk("t9_rst_sda", {31'b0, sda_bus}, 32'd1);
        chk("t9_rst_busy", {31'b0, busy}, 32'd0);
        chk("t9_rst_wr_addr", {16'h0, wr_addr}, 32'd0);
        chk("t9_rst_wr_data", {24'h0, wr_data}, 32'd0);
        scl_drv = 1'b1;
        qwait(3 * Q);
        rst = 1'b0;
        qwait(2 * Q);

        #1;
        chk("wr_queue_drained", wr_q.size(), 32'd0);
        chk("rd_queue_drained", rd_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
